// File: rtl/soc_pio_pkg.sv
// Shared definitions for the SoC PIO family: register map and edge-select encoding.
package soc_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } pio_edge_e;

endpackage

// File: rtl/soc_pio_sync.sv
// WIDTH x STAGES flop synchronizer, async active-low reset, all stages clear to 0.
module soc_pio_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/soc_pio_in_edge.sv
// Avalon-MM input PIO with per-bit edge capture and masked level irq.
// IRQMASK and irq are only implemented when SOC_PIO_IN_IRQ_EN is defined.
module soc_pio_in_edge
  import soc_pio_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  output logic              irq
);

  localparam pio_edge_e EDGE = pio_edge_e'(EDGE_TYPE);

  logic [DATA_W-1:0] sync_w, edge_w, wdata_w;
  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] edgecap_q, edgecap_d;
  logic [DATA_W-1:0] irqmask_q;
  logic [31:0]       readdata_q, readdata_d;
  logic              wr_en;

  soc_pio_sync #(.WIDTH(DATA_W), .STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (in_port),
    .q_o     (sync_w)
  );

  assign wr_en   = chipselect & ~write_n;
  assign wdata_w = writedata[DATA_W-1:0];

  always_comb begin
    case (EDGE)
      EDGE_FALL: edge_w = ~sync_w & prev_q;
      EDGE_ANY:  edge_w = sync_w ^ prev_q;
      default:   edge_w = sync_w & ~prev_q;
    endcase
  end

  // A new edge overrides a same-cycle W1C on that bit.
  always_comb begin
    edgecap_d = edgecap_q;
    if (wr_en && address == PIO_ADDR_EDGECAP) edgecap_d = edgecap_q & ~wdata_w;
    edgecap_d = edgecap_d | edge_w;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= '0;
      edgecap_q <= '0;
    end else begin
      prev_q    <= sync_w;
      edgecap_q <= edgecap_d;
    end
  end

`ifdef SOC_PIO_IN_IRQ_EN
  logic [DATA_W-1:0] irqmask_d;

  always_comb begin
    irqmask_d = irqmask_q;
    if (wr_en && address == PIO_ADDR_IRQMASK) irqmask_d = wdata_w;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irqmask_q <= '0;
    else          irqmask_q <= irqmask_d;
  end

  assign irq = |(edgecap_q & irqmask_q);
`else
  assign irqmask_q = '0;
  assign irq       = 1'b0;
`endif

  always_comb begin
    readdata_d = '0;
    case (address)
      PIO_ADDR_DATA:    readdata_d[DATA_W-1:0] = sync_w;
      PIO_ADDR_IRQMASK: readdata_d[DATA_W-1:0] = irqmask_q;
      PIO_ADDR_EDGECAP: readdata_d[DATA_W-1:0] = edgecap_q;
      default:          readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;

endmodule
